// File: rtl/rock_sequencer.sv
// Motion-program controller: ramps Freq/Amp setpoints up to latched targets,
// holds for HOLD_STEPS ticks, then ramps back to zero. Cry re-rocks, Stop winds down.
module rock_sequencer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int HOLD_STEPS = 30
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Cry,
    input  logic [2:0] TargetFreq,
    input  logic [2:0] TargetAmp,
    output logic [2:0] Freq,
    output logic [2:0] Amp,
    output logic       Busy,
    output logic [1:0] State
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_HOLD = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t          r_state, w_nstate;
    logic [PW-1:0]   r_pre,   w_npre;
    logic [HW-1:0]   r_hold,  w_nhold;
    logic [2:0]      r_freq,  w_nfreq;
    logic [2:0]      r_amp,   w_namp;
    logic [2:0]      r_tf,    w_ntf;
    logic [2:0]      r_ta,    w_nta;

    logic            w_tick;
    logic [2:0]      w_f_up, w_a_up, w_f_dn, w_a_dn;
    logic [HW-1:0]   w_hold_inc;

    assign w_tick     = (r_state != S_IDLE) && (r_pre == PW'(TICK_DIV - 1));
    assign w_f_up     = (r_freq < r_tf) ? r_freq + 3'd1 : r_freq;
    assign w_a_up     = (r_amp  < r_ta) ? r_amp  + 3'd1 : r_amp;
    assign w_f_dn     = (r_freq != 3'd0) ? r_freq - 3'd1 : r_freq;
    assign w_a_dn     = (r_amp  != 3'd0) ? r_amp  - 3'd1 : r_amp;
    assign w_hold_inc = r_hold + HW'(1);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_hold  <= '0;
            r_freq  <= 3'd0;
            r_amp   <= 3'd0;
            r_tf    <= 3'd0;
            r_ta    <= 3'd0;
        end else begin
            r_state <= w_nstate;
            r_pre   <= w_npre;
            r_hold  <= w_nhold;
            r_freq  <= w_nfreq;
            r_amp   <= w_namp;
            r_tf    <= w_ntf;
            r_ta    <= w_nta;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_npre   = w_tick ? '0 : r_pre + PW'(1);
        w_nhold  = r_hold;
        w_nfreq  = r_freq;
        w_namp   = r_amp;
        w_ntf    = r_tf;
        w_nta    = r_ta;
        case (r_state)
            S_IDLE: begin
                w_npre  = '0;
                w_nhold = '0;
                if (Start) begin
                    w_nstate = S_UP;
                    w_ntf    = TargetFreq;
                    w_nta    = TargetAmp;
                end
            end
            S_UP: begin
                if (Stop) begin
                    w_nstate = S_DOWN;
                end else if (w_tick) begin
                    w_nfreq = w_f_up;
                    w_namp  = w_a_up;
                    if (w_f_up == r_tf && w_a_up == r_ta)
                        w_nstate = S_HOLD;
                end
            end
            S_HOLD: begin
                // Cry restarts the whole hold window, prescaler included
                if (Stop) begin
                    w_nstate = S_DOWN;
                end else if (Cry) begin
                    w_npre  = '0;
                    w_nhold = '0;
                end else if (w_tick) begin
                    if (w_hold_inc == HW'(HOLD_STEPS))
                        w_nstate = S_DOWN;
                    else
                        w_nhold = w_hold_inc;
                end
            end
            S_DOWN: begin
                // Stop outranks Cry, so a simultaneous pair keeps ramping down
                if (Cry && !Stop) begin
                    w_nstate = S_UP;
                end else if (w_tick) begin
                    w_nfreq = w_f_dn;
                    w_namp  = w_a_dn;
                    if (w_f_dn == 3'd0 && w_a_dn == 3'd0)
                        w_nstate = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
        if (w_nstate != r_state) begin
            w_npre  = '0;
            w_nhold = '0;
        end
    end

    assign Freq  = r_freq;
    assign Amp   = r_amp;
    assign State = r_state;
    assign Busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_rock_sequencer.sv
// Bench for rock_sequencer: directed vector table, hand-written corner sequences,
// then random stimulus against a behavioural reference model.
module tb_rock_sequencer;
    localparam int TD = 4;
    localparam int HS = 2;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0, Start = 1'b0, Stop = 1'b0, Cry = 1'b0;
    logic [2:0] TargetFreq = 3'd0, TargetAmp = 3'd0;
    logic [2:0] Freq, Amp;
    logic       Busy;
    logic [1:0] State;

    rock_sequencer #(.TICK_DIV(TD), .HOLD_STEPS(HS)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Cry(Cry),
        .TargetFreq(TargetFreq), .TargetAmp(TargetAmp),
        .Freq(Freq), .Amp(Amp), .Busy(Busy), .State(State)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0..3, cycles since phase entry, ticks spent holding
    int m_st = 0, m_f = 0, m_a = 0, m_tf = 0, m_ta = 0, m_age = 0, m_held = 0;

    task automatic model_step();
        int  nst;
        bit  tick;
        if (!Reset) begin
            m_st = 0; m_f = 0; m_a = 0; m_tf = 0; m_ta = 0; m_age = 0; m_held = 0;
            return;
        end
        tick = (m_st != 0) && (((m_age + 1) % TD) == 0);
        nst  = m_st;
        case (m_st)
            0: if (Start) begin nst = 1; m_tf = TargetFreq; m_ta = TargetAmp; end
            1: if (Stop) nst = 3;
               else if (tick) begin
                   m_f = (m_f < m_tf) ? m_f + 1 : m_f;
                   m_a = (m_a < m_ta) ? m_a + 1 : m_a;
                   if (m_f == m_tf && m_a == m_ta) nst = 2;
               end
            2: if (Stop) nst = 3;
               else if (Cry) begin m_age = -1; m_held = 0; end
               else if (tick) begin
                   m_held++;
                   if (m_held == HS) nst = 3;
               end
            default: if (Cry && !Stop) nst = 1;
               else if (tick) begin
                   m_f = (m_f > 0) ? m_f - 1 : 0;
                   m_a = (m_a > 0) ? m_a - 1 : 0;
                   if (m_f == 0 && m_a == 0) nst = 0;
               end
        endcase
        if (nst != m_st) begin m_age = 0; m_held = 0; end
        else m_age++;
        m_st = nst;
    endtask

    task automatic drive(input bit r, input bit s, input bit p, input bit c,
                         input int tf, input int ta);
        Reset = r; Start = s; Stop = p; Cry = c;
        TargetFreq = 3'(tf); TargetAmp = 3'(ta);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            model_step();
            @(negedge CLK);
        end
    endtask

    task automatic check(input string nm, input int st, input int f, input int a);
        n_tests++;
        if (State !== 2'(st) || Freq !== 3'(f) || Amp !== 3'(a) || Busy !== (st != 0)) begin
            n_fail++;
            $display("FAIL %s: got st=%0d f=%0d a=%0d busy=%0b, want st=%0d f=%0d a=%0d busy=%0b",
                     nm, State, Freq, Amp, Busy, st, f, a, (st != 0));
        end
    endtask

    typedef struct {
        bit rst, start, stop, cry;
        int tf, ta, ncyc;
        int st, f, a;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Full program tF=3/tA=5; targets driven to 0 after start must be ignored
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3, 5, 2, 0, 0, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3, 5, 1, 1, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1, 1, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 2, 2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 3, 3});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 3, 4});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 3, 4});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 2, 3, 5});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 7, 2, 3, 5});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 3, 3, 5});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 3, 2, 4});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 3, 1, 3});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 3, 0, 2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 3, 0, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 3, 0, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].cry, tbl[i].tf, tbl[i].ta);
            run(tbl[i].ncyc);
            check($sformatf("tbl%0d", i), tbl[i].st, tbl[i].f, tbl[i].a);
        end

        // Cry one tick into HOLD restarts the window; targets changed while busy
        drive(1, 1, 0, 0, 3, 5); run(1);
        drive(1, 0, 0, 0, 1, 1); run(20);
        check("cryA_hold", 2, 3, 5);
        run(4);
        drive(1, 0, 0, 1, 1, 1); run(1);
        drive(1, 0, 0, 0, 1, 1); run(7);
        check("cryA_still_hold", 2, 3, 5);
        run(1);
        check("cryA_down", 3, 3, 5);
        run(4);
        check("cryB_24", 3, 2, 4);
        drive(1, 0, 0, 1, 1, 1); run(1);
        check("cryB_up", 1, 2, 4);
        drive(1, 0, 0, 0, 1, 1); run(3);
        check("cryB_wait", 1, 2, 4);
        run(1);
        check("cryB_hold", 2, 3, 5);
        drive(1, 1, 1, 1, 1, 1); run(1);
        check("stopcry_hold", 3, 3, 5);
        drive(1, 0, 0, 0, 1, 1); run(20);
        check("stopcry_idle", 0, 0, 0);

        // Stop during RAMP_UP keeps the current values
        drive(1, 1, 0, 0, 3, 5); run(1);
        drive(1, 1, 0, 0, 7, 7); run(8);
        check("stopup_22", 1, 2, 2);
        drive(1, 0, 1, 0, 7, 7); run(1);
        check("stopup_down", 3, 2, 2);
        drive(1, 0, 0, 0, 0, 0); run(4);
        check("stopup_11", 3, 1, 1);
        run(4);
        check("stopup_idle", 0, 0, 0);

        // Zero targets: first tick lands in HOLD at 0/0
        drive(1, 1, 0, 0, 0, 0); run(1);
        drive(1, 0, 0, 0, 7, 7); run(3);
        check("zero_up", 1, 0, 0);
        run(1);
        check("zero_hold", 2, 0, 0);
        run(8);
        check("zero_down", 3, 0, 0);
        run(4);
        check("zero_idle", 0, 0, 0);

        // Reset mid-HOLD with Start held through it
        drive(1, 1, 0, 0, 3, 5); run(1);
        drive(1, 0, 0, 0, 3, 5); run(22);
        check("rst_prehold", 2, 3, 5);
        drive(0, 1, 0, 0, 3, 5); run(1);
        check("rst_clear", 0, 0, 0);
        drive(1, 1, 0, 0, 3, 5); run(1);
        check("rst_restart", 1, 0, 0);
        drive(1, 0, 1, 0, 3, 5); run(1);
        check("rst_stop", 3, 0, 0);
        drive(1, 0, 0, 0, 3, 5); run(4);
        check("rst_idle", 0, 0, 0);

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            run(1);
            n_tests++;
            if (State !== 2'(m_st) || Freq !== 3'(m_f) || Amp !== 3'(m_a) || Busy !== (m_st != 0)) begin
                n_fail++;
                $display("FAIL rnd%0d: got st=%0d f=%0d a=%0d busy=%0b, want st=%0d f=%0d a=%0d",
                         i, State, Freq, Amp, Busy, m_st, m_f, m_a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
